// File: rtl/perf_counter_pkg.sv
// perf_counter_pkg: shared encodings for the performance-counter poller.
// Command ops, slave word offsets, section stride and FSM states.
package perf_counter_pkg;

  typedef enum logic [1:0] {
    OP_START        = 2'd0,
    OP_STOP         = 2'd1,
    OP_SNAPSHOT     = 2'd2,
    OP_GLOBAL_RESET = 2'd3
  } cmd_op_e;

  localparam logic [1:0] OFS_TIME_LO = 2'd0;
  localparam logic [1:0] OFS_TIME_HI = 2'd1;
  localparam logic [1:0] OFS_EVENT   = 2'd2;

  localparam int SECTION_STRIDE = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_WAIT,
    RESULT
  } state_e;

  typedef enum logic [1:0] {
    RS_LO,
    RS_HI,
    RS_HI2,
    RS_EV
  } rd_step_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_ISSUE,
    P_WAIT
  } port_state_e;

  function automatic logic [1:0] step_ofs(input rd_step_e s);
    logic [1:0] ofs;
    unique case (s)
      RS_LO:         ofs = OFS_TIME_LO;
      RS_HI, RS_HI2: ofs = OFS_TIME_HI;
      default:       ofs = OFS_EVENT;
    endcase
    return ofs;
  endfunction

endpackage

// File: rtl/perf_counter_avm_port.sv
// perf_counter_avm_port: single-transaction Avalon-MM issue/wait engine.
// Latches one request on start, holds it through waitrequest, waits for read data.
module perf_counter_avm_port
  import perf_counter_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              accepted,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);

  port_state_e       st_q, st_d;
  logic              rnw_q, rnw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  always_comb begin
    st_d    = st_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (st_q)
      P_ISSUE: if (!avm_waitrequest) st_d = rnw_q ? P_WAIT : P_IDLE;
      P_WAIT:  if (avm_readdatavalid) st_d = P_IDLE;
      default: ;
    endcase
    // A new request may be chained onto the data-return cycle.
    if (start) begin
      st_d    = P_ISSUE;
      rnw_d   = rnw;
      addr_d  = addr;
      wdata_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= P_IDLE;
      rnw_q   <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      st_q    <= st_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign accepted      = (st_q == P_ISSUE) && !avm_waitrequest;
  assign rvalid        = (st_q == P_WAIT) && avm_readdatavalid;
  assign rdata         = avm_readdata;
  assign avm_read      = !reset && (st_q == P_ISSUE) && rnw_q;
  assign avm_write     = !reset && (st_q == P_ISSUE) && !rnw_q;
  assign avm_address   = reset ? '0 : addr_q;
  assign avm_writedata = reset ? '0 : wdata_q;

endmodule

// File: rtl/perf_counter_poller.sv
// perf_counter_poller: command-driven Avalon-MM master for the perf-counter slave.
// Define PERF_COUNTER_POLLER_COHERENT_READ_EN for hi/lo/hi2 coherent time reads.
module perf_counter_poller
  import perf_counter_pkg::*;
#(
  parameter int NUM_SECTIONS = 4,
  parameter int ADDR_W       = 4,
  parameter int MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_section,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_section,
  output logic [63:0]       res_time,
  output logic [31:0]       res_events,
  output logic              res_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);

`ifdef PERF_COUNTER_POLLER_COHERENT_READ_EN
  localparam rd_step_e FIRST_STEP = RS_HI;
  localparam rd_step_e AFTER_LO   = RS_HI2;
  localparam rd_step_e AFTER_HI   = RS_LO;
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_q, retry_d;
`else
  localparam rd_step_e FIRST_STEP = RS_LO;
  localparam rd_step_e AFTER_LO   = RS_HI;
  localparam rd_step_e AFTER_HI   = RS_EV;
  // Retry limit only matters for the coherent build.
  if (MAX_RETRY < 0) begin : g_bad_max_retry
  end
`endif

  state_e            st_q, st_d;
  rd_step_e          step_q, step_d;
  logic [1:0]        sec_q, sec_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       ev_q, ev_d;
  logic              err_q, err_d;
  logic              start;
  logic              rnw;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              accepted;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              in_range;
  cmd_op_e           op;

  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [1:0] sec,
    input logic [1:0] ofs
  );
    return ADDR_W'(int'(sec) * SECTION_STRIDE + int'(ofs));
  endfunction

  always_comb begin
    st_d      = st_q;
    step_d    = step_q;
    sec_d     = sec_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    ev_d      = ev_q;
    err_d     = err_q;
    start     = 1'b0;
    rnw       = 1'b1;
    addr      = word_addr(sec_q, step_ofs(step_q));
    wdata     = '0;
    cmd_ready = 1'b0;
    op        = cmd_op_e'(cmd_op);
    in_range  = int'(cmd_section) < NUM_SECTIONS;
`ifdef PERF_COUNTER_POLLER_COHERENT_READ_EN
    retry_d   = retry_q;
`endif
    unique case (st_q)
      IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid && !reset) begin
          sec_d = cmd_section;
          unique case (1'b1)
            (op == OP_START), (op == OP_STOP): begin
              if (in_range) begin
                start = 1'b1;
                rnw   = 1'b0;
                addr  = word_addr(cmd_section,
                  (op == OP_START) ? OFS_TIME_HI : OFS_TIME_LO);
                st_d  = WR;
              end
            end
            (op == OP_GLOBAL_RESET): begin
              start = 1'b1;
              rnw   = 1'b0;
              addr  = '0;
              wdata = 32'd1;
              st_d  = WR;
            end
            (op == OP_SNAPSHOT): begin
              lo_d  = '0;
              hi_d  = '0;
              ev_d  = '0;
              err_d = !in_range;
`ifdef PERF_COUNTER_POLLER_COHERENT_READ_EN
              retry_d = '0;
`endif
              if (in_range) begin
                start  = 1'b1;
                step_d = FIRST_STEP;
                addr   = word_addr(cmd_section, step_ofs(FIRST_STEP));
                st_d   = RD_REQ;
              end else begin
                st_d = RESULT;
              end
            end
            default: ;
          endcase
        end
      end
      WR:     if (accepted) st_d = IDLE;
      RD_REQ: if (accepted) st_d = RD_WAIT;
      RD_WAIT: begin
        if (rvalid) begin
          start = 1'b1;
          st_d  = RD_REQ;
          case (step_q)
            RS_LO: begin
              lo_d   = rdata;
              step_d = AFTER_LO;
            end
            RS_HI: begin
              hi_d   = rdata;
              step_d = AFTER_HI;
            end
`ifdef PERF_COUNTER_POLLER_COHERENT_READ_EN
            RS_HI2: begin
              if (rdata == hi_q) begin
                step_d = RS_EV;
              end else begin
                hi_d = rdata;
                if (retry_q == RETRY_W'(MAX_RETRY)) begin
                  err_d  = 1'b1;
                  step_d = RS_EV;
                end else begin
                  retry_d = retry_q + 1'b1;
                  step_d  = RS_LO;
                end
              end
            end
`endif
            default: begin
              ev_d  = rdata;
              start = 1'b0;
              st_d  = RESULT;
            end
          endcase
          addr = word_addr(sec_q, step_ofs(step_d));
        end
      end
      RESULT: if (res_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      step_q <= RS_LO;
      sec_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      ev_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      step_q <= step_d;
      sec_q  <= sec_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      ev_q   <= ev_d;
      err_q  <= err_d;
    end
  end

`ifdef PERF_COUNTER_POLLER_COHERENT_READ_EN
  always_ff @(posedge clk) begin
    if (reset) retry_q <= '0;
    else       retry_q <= retry_d;
  end
`endif

  assign res_valid   = !reset && (st_q == RESULT);
  assign res_section = reset ? '0 : sec_q;
  assign res_time    = reset ? '0 : {hi_q, lo_q};
  assign res_events  = reset ? '0 : ev_q;
  assign res_err     = !reset && err_q;

  perf_counter_avm_port #(
    .ADDR_W(ADDR_W)
  ) u_port (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .rnw               (rnw),
    .addr              (addr),
    .wdata             (wdata),
    .accepted          (accepted),
    .rvalid            (rvalid),
    .rdata             (rdata),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid)
  );

endmodule

// File: tb/tb_perf_counter_poller.sv
// tb_perf_counter_poller: self-checking bench for perf_counter_poller.
// Avalon slave model, write-command table, hand sequences and random snapshots.
`timescale 1ns/1ps
module tb_perf_counter_poller;

  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_SNAP  = 2'd2;
  localparam logic [1:0] C_GRST  = 2'd3;
  localparam int NSEC = 3;
`ifdef PERF_COUNTER_POLLER_COHERENT_READ_EN
  localparam int SNAP_READS = 4;
`else
  localparam int SNAP_READS = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [1:0]  cmd_section = 2'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [1:0]  res_section;
  logic [63:0] res_time;
  logic [31:0] res_events;
  logic        res_err;
  logic [3:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;

  perf_counter_poller #(
    .NUM_SECTIONS(NSEC),
    .ADDR_W(4),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_section(cmd_section),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_section(res_section), .res_time(res_time),
    .res_events(res_events), .res_err(res_err),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          cycles;
    bit          stable;
  } wr_t;

  logic [31:0] mem [16];
  logic [31:0] script [$];
  wr_t         wlog [$];
  int          stall_cfg = 0;
  int          stall_q = 0;
  int          reads = 0;
  int          wcyc = 0;
  bit          wstable = 1'b1;
  logic [3:0]  wa = '0;
  logic [31:0] wd = '0;
  logic        rdv_q = 1'b0;
  logic [31:0] rd_q = '0;
  logic        spur_rdv = 1'b0;

  assign avm_waitrequest   = (avm_read || avm_write) && (stall_q < stall_cfg);
  assign avm_readdatavalid = rdv_q || spur_rdv;
  assign avm_readdata      = rd_q;

  always @(posedge clk) begin
    rdv_q <= 1'b0;
    if (reset) begin
      stall_q <= 0;
      wcyc    <= 0;
    end else begin
      if (avm_read || avm_write)
        stall_q <= avm_waitrequest ? stall_q + 1 : 0;
      if (avm_read && !avm_waitrequest) begin
        rdv_q <= 1'b1;
        reads <= reads + 1;
        if (script.size() != 0) rd_q <= script.pop_front();
        else                    rd_q <= mem[avm_address];
      end
      if (avm_write) begin
        if (avm_waitrequest) begin
          wcyc <= wcyc + 1;
          wa   <= avm_address;
          wd   <= avm_writedata;
          wstable <= (wcyc == 0) ? 1'b1 :
            (wstable && wa == avm_address && wd == avm_writedata);
        end else begin
          wlog.push_back('{avm_address, avm_writedata, wcyc + 1,
            (wcyc == 0) || (wstable && wa == avm_address &&
            wd == avm_writedata)});
          wcyc <= 0;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] sec);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_section = sec;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit saw_res);
    int n = 0;
    saw_res = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (res_valid) saw_res = 1'b1;
    end while (!cmd_ready && n < 200);
    chk("idle_wait", cmd_ready, 1'b1);
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 300);
    chk("res_valid_wait", res_valid, 1'b1);
  endtask

  task automatic take_res(input int hold, output logic [127:0] rec,
                          output bit stable_ok);
    logic [127:0] cur;
    rec = {29'd0, res_section, res_err, res_time, res_events};
    stable_ok = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      cur = {29'd0, res_section, res_err, res_time, res_events};
      if (!res_valid || cur != rec || cmd_ready) stable_ok = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  function automatic logic [127:0] mk_rec(input logic [1:0] sec,
    input logic err, input logic [63:0] t, input logic [31:0] ev);
    return {29'd0, sec, err, t, ev};
  endfunction

  // ---------------- write command table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sec;
    int          stall;
    bit          bus;
    logic [3:0]  addr;
    logic [31:0] data;
    int          cycles;
  } wvec_t;

  wvec_t        wtab [8];
  logic [127:0] rec;
  int           lat;
  int           r0;
  bit           st;
  bit           saw;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    wtab[0] = '{C_START, 2'd0, 0, 1'b1, 4'd1, 32'd0, 1};
    wtab[1] = '{C_STOP,  2'd0, 0, 1'b1, 4'd0, 32'd0, 1};
    wtab[2] = '{C_START, 2'd2, 3, 1'b1, 4'd9, 32'd0, 4};
    wtab[3] = '{C_STOP,  2'd1, 1, 1'b1, 4'd4, 32'd0, 2};
    wtab[4] = '{C_GRST,  2'd3, 0, 1'b1, 4'd0, 32'd1, 1};
    wtab[5] = '{C_GRST,  2'd1, 2, 1'b1, 4'd0, 32'd1, 3};
    wtab[6] = '{C_START, 2'd3, 0, 1'b0, 4'd0, 32'd0, 0};
    wtab[7] = '{C_STOP,  2'd3, 0, 1'b0, 4'd0, 32'd0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {cmd_ready, res_valid, res_err, avm_read, avm_write},
        5'b0);
    chk("reset_data", {res_section, res_time, res_events}, 98'b0);
    chk("reset_bus", {avm_address, avm_writedata}, 36'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1'b1);

    // Write / dropped commands
    for (int i = 0; i < 8; i++) begin
      wlog.delete();
      stall_cfg = wtab[i].stall;
      send(wtab[i].op, wtab[i].sec);
      wait_idle(saw);
      chk($sformatf("wr%0d_count", i), wlog.size(), wtab[i].bus ? 1 : 0);
      chk($sformatf("wr%0d_nores", i), saw, 1'b0);
      if (wtab[i].bus && wlog.size() == 1) begin
        chk($sformatf("wr%0d_addr", i), wlog[0].addr, wtab[i].addr);
        chk($sformatf("wr%0d_data", i), wlog[0].data, wtab[i].data);
        chk($sformatf("wr%0d_cycles", i), wlog[0].cycles, wtab[i].cycles);
        chk($sformatf("wr%0d_stable", i), wlog[0].stable, 1'b1);
      end
    end
    stall_cfg = 0;

    // Global reset then minimum-latency snapshot
    send(C_GRST, 2'd0);
    wait_idle(saw);
    mem[0] = 32'h10;
    mem[1] = 32'h0;
    mem[2] = 32'h0;
    send(C_SNAP, 2'd0);
    wait_res(lat);
    chk("snap0_latency", lat, 7);
    take_res(0, rec, st);
    chk("snap0_rec", rec, mk_rec(2'd0, 1'b0, 64'h10, 32'd0));

    // Backpressured result
    mem[4] = 32'hFFFF_FFFF;
    mem[5] = 32'd5;
    mem[6] = 32'd7;
    send(C_SNAP, 2'd1);
    wait_res(lat);
    take_res(10, rec, st);
    chk("snap1_rec", rec, mk_rec(2'd1, 1'b0, 64'h5_FFFF_FFFF, 32'd7));
    chk("snap1_stable", st, 1'b1);
    @(negedge clk);
    chk("snap1_released", {res_valid, cmd_ready}, 2'b01);
    wlog.delete();
    send(C_STOP, 2'd1);
    wait_idle(saw);
    chk("after_res_cmd", wlog.size(), 1);

    // Out-of-range snapshot
    r0 = reads;
    send(C_SNAP, 2'd3);
    wait_res(lat);
    chk("oor_latency", lat <= 2, 1'b1);
    take_res(0, rec, st);
    chk("oor_rec", rec, mk_rec(2'd3, 1'b1, 64'd0, 32'd0));
    chk("oor_noread", reads - r0, 0);

    // Reset during a stalled read
    stall_cfg = 1000;
    send(C_SNAP, 2'd0);
    @(negedge clk);
    @(negedge clk);
    chk("stall_read_on", avm_read, 1'b1);
    reset = 1'b1;
    #1;
    chk("reset_drop_read", avm_read, 1'b0);
    @(negedge clk);
    chk("reset_hold", {avm_read, cmd_ready, res_valid}, 3'b0);
    stall_cfg = 0;
    reset = 1'b0;
    r0 = reads;
    spur_rdv = 1'b1;
    @(negedge clk);
    spur_rdv = 1'b0;
    chk("post_reset_ready", cmd_ready, 1'b1);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (res_valid || !cmd_ready || avm_read) saw = 1'b1;
    end
    chk("spurious_rdv_ignored", saw, 1'b0);
    chk("post_reset_noread", reads - r0, 0);

`ifdef PERF_COUNTER_POLLER_COHERENT_READ_EN
    script = '{32'd4, 32'd2, 32'd5, 32'd1, 32'd5, 32'd9};
    r0 = reads;
    send(C_SNAP, 2'd0);
    wait_res(lat);
    take_res(0, rec, st);
    chk("coh_retry_rec", rec, mk_rec(2'd0, 1'b0, 64'h5_0000_0001, 32'd9));
    chk("coh_retry_reads", reads - r0, 6);
    script = '{32'd0, 32'd10, 32'd1, 32'd11, 32'd2, 32'd12,
               32'd3, 32'd13, 32'd4, 32'd9};
    r0 = reads;
    send(C_SNAP, 2'd0);
    wait_res(lat);
    take_res(0, rec, st);
    chk("coh_limit_rec", rec, mk_rec(2'd0, 1'b1, 64'h4_0000_000D, 32'd9));
    chk("coh_limit_reads", reads - r0, 10);
`endif

    // Random traffic against a simple register-file model
    for (int it = 0; it < 60; it++) begin
      logic [1:0]   op;
      logic [1:0]   sec;
      bit           ok;
      logic [3:0]   ea;
      logic [127:0] erec;
      op  = 2'($urandom_range(0, 3));
      sec = 2'($urandom_range(0, 3));
      ok  = int'(sec) < NSEC;
      stall_cfg = int'($urandom_range(0, 2));
      if (op == C_SNAP) begin
        if (ok)
          for (int k = 0; k < 3; k++) mem[4 * sec + k] = $urandom;
        erec = ok ? mk_rec(sec, 1'b0, {mem[4 * sec + 1], mem[4 * sec]},
                           mem[4 * sec + 2])
                  : mk_rec(sec, 1'b1, 64'd0, 32'd0);
        r0 = reads;
        send(op, sec);
        wait_res(lat);
        take_res(int'($urandom_range(0, 3)), rec, st);
        chk($sformatf("rnd%0d_rec", it), rec, erec);
        chk($sformatf("rnd%0d_reads", it), reads - r0, ok ? SNAP_READS : 0);
        chk($sformatf("rnd%0d_stable", it), st, 1'b1);
      end else begin
        ok = ok || (op == C_GRST);
        ea = (op == C_GRST) ? 4'd0 : 4'(4 * sec + ((op == C_START) ? 1 : 0));
        wlog.delete();
        send(op, sec);
        wait_idle(saw);
        chk($sformatf("rnd%0d_wcount", it), wlog.size(), ok ? 1 : 0);
        chk($sformatf("rnd%0d_nores", it), saw, 1'b0);
        if (ok && wlog.size() == 1)
          chk($sformatf("rnd%0d_write", it), {wlog[0].addr, wlog[0].data},
              {ea, (op == C_GRST) ? 32'd1 : 32'd0});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_counter_poller.md
Name: perf_counter_poller

Overview:
- Avalon-MM master that drives the 16-word performance-counter control slave.
- Sections are at base 4*s: +0 time_lo/stop, +1 time_hi/go, +2 event count.
- Accepts simple commands (start, stop, global reset, snapshot) from a local controller (DMA or sequencer) and issues the matching slave writes/reads.
- Snapshot results return as one 96-bit record on a valid/ready result port, so firmware no longer polls the counter over the CPU bus.

Parameters:
- NUM_SECTIONS, 4, number of counter sections implemented in the slave (1..4)
- ADDR_W, 4, Avalon word-address width of the slave
- MAX_RETRY, 3, coherent-read retry limit before flagging an error

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  0=START, 1=STOP, 2=SNAPSHOT, 3=GLOBAL_RESET
- cmd_section  in  2  target section (ignored for GLOBAL_RESET)
- res_valid  out  1  snapshot result present
- res_ready  in  1  result consumed when res_valid & res_ready
- res_section  out  2  section of the result
- res_time  out  64  {time_hi, time_lo}
- res_events  out  32  event count
- res_err  out  1  out-of-range section, or retry limit hit
- avm_address  out  ADDR_W  word address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall
- avm_readdatavalid  in  1  read data qualifier

Behaviour:
- Reset: every output is 0, including cmd_ready; the FSM goes to IDLE.
  - Reset mid-transfer drops avm_read/avm_write in the same cycle and discards any later readdatavalid.
- FSM states: IDLE, WR, RD_REQ, RD_WAIT, RESULT.
  - cmd_ready=1 only in IDLE with no result pending.
- Command acceptance:
  - START: WR at 4s+1, writedata 0.
  - STOP: WR at 4s+0, writedata 0.
  - GLOBAL_RESET: WR at address 0, writedata 1.
  - SNAPSHOT: goes to RD_REQ.
- Out-of-range section (cmd_section >= NUM_SECTIONS):
  - START/STOP are dropped with no bus cycle.
  - SNAPSHOT goes straight to RESULT with res_err=1 and res_time=res_events=0.
- WR: avm_write, address and data are held stable while avm_waitrequest=1; on the first cycle with waitrequest=0, return to IDLE. Writes produce no result.
- Reads:
  - At most one read outstanding.
  - RD_REQ holds avm_read and address until waitrequest=0, then moves to RD_WAIT.
  - RD_WAIT captures avm_readdata on readdatavalid. The slave has 1-cycle registered read latency; any latency ≥1 is tolerated.
  - readdatavalid in any other state is ignored.
- Snapshot sequence without the macro: lo (4s+0), hi (4s+1), event (4s+2).
- Result presentation: RESULT asserts res_valid; all res_* fields stay stable until res_ready. Leave RESULT the cycle after the handshake.
- Minimum snapshot length: 3 reads × (1 issue + 1 data) + 1 result = 7 cycles with no stalls.
- Widths: addresses are formed as {section, 2'bXX} within ADDR_W; the event count is 32 bits (the slave returns only its low word).

Optional Feature:
- Macro: PERF_COUNTER_POLLER_COHERENT_READ_EN.
- Defined: snapshot reads hi, lo, hi2.
  - If hi2 == hi, accept {hi, lo}.
  - Otherwise set hi=hi2 and re-read lo, then hi2, up to MAX_RETRY times; after that, report the last values with res_err=1.
  - Then read event.
- Not defined: the plain lo, hi, event sequence, with no retry logic or retry counter synthesized. The time value may be torn across a lo-word carry.

Decomposition:
- Package perf_counter_pkg holds:
  - cmd_op encodings
  - slave word offsets (OFS_TIME_LO=0, OFS_TIME_HI=1, OFS_EVENT=2)
  - SECTION_STRIDE=4
  - FSM state enum
- Natural sub-module: perf_counter_avm_port, a single-transaction Avalon-MM master issue/wait engine (req, rnw, addr, wdata → done, rdata) shared by the write and read paths.

Test Plan:
- Reset while RD_REQ is asserted with waitrequest=1 → next cycle avm_read=0, cmd_ready=1 after reset release, no res_valid.
- START sec 2, waitrequest high 3 cycles → avm_write held at address 9, writedata 0 for 4 cycles, then IDLE; no result.
- GLOBAL_RESET then SNAPSHOT sec 0 on a zero-latency slave model returning lo=0x10, hi=0, ev=0 → res_time=0x10, res_events=0, res_err=0, 7 cycles from accept to res_valid.
- SNAPSHOT sec 1, slave returns lo=0xFFFF_FFFF, hi=5, ev=7, res_ready held low 10 cycles → fields stable, cmd_ready=0 throughout; accepted after res_ready.
- SNAPSHOT with cmd_section=3, NUM_SECTIONS=2 → no avm_read, res_err=1 within 2 cycles.
- Macro on: hi=4, lo=0x2, hi2=5, then lo=0x1, hi2=5 → res_time=0x5_0000_0001, one retry. Constant mismatch → res_err=1 after MAX_RETRY=3 retries.
